// File: rtl/prim_core_param.sv
// Tiny multi-cycle programmable core: loadable program memory, register file,
// signed branches and a valid-flagged result port for the HEX display path.
module prim_core_param #(
   parameter int DATA_W     = 32,
   parameter int REG_CNT    = 16,
   parameter int PROG_DEPTH = 64,
   parameter int PA_W       = $clog2(PROG_DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              prog_we_i,
   input  logic [PA_W-1:0]   prog_addr_i,
   input  logic [31:0]       prog_data_i,
   output logic [DATA_W-1:0] result_o,
   output logic              result_valid_o,
   output logic              busy_o,
   output logic              halt_o,
   output logic              err_o
);

   localparam int RI_W = $clog2(REG_CNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HALT
   } state_e;

   logic [31:0]       mem_q [PROG_DEPTH];
   state_e            state_q, state_d;
   logic [PA_W-1:0]   pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [DATA_W-1:0] rf_q [REG_CNT];
   logic [DATA_W-1:0] rf_d [REG_CNT];
   logic [DATA_W-1:0] result_q, result_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              mem_we;

   logic [3:0]        op;
   logic [RI_W-1:0]   rd, rs1, rs2;
   logic [31:0]       imm32;
   logic [DATA_W-1:0] imm, a, b;
   logic [PA_W-1:0]   pc_br;
   logic              wr_en;
   logic [DATA_W-1:0] wr_val;

   assign op    = instr_q[31:28];
   assign rd    = instr_q[24 +: RI_W];
   assign rs1   = instr_q[20 +: RI_W];
   assign rs2   = instr_q[16 +: RI_W];
   assign imm32 = {{16{instr_q[15]}}, instr_q[15:0]};
   assign imm   = imm32[DATA_W-1:0];
   assign a     = rf_q[rs1];
   assign b     = rf_q[rs2];
   assign pc_br = pc_q + imm32[PA_W-1:0];

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      rf_d     = rf_q;
      result_d = result_q;
      valid_d  = 1'b0;
      err_d    = err_q;
      mem_we   = 1'b0;
      wr_en    = 1'b0;
      wr_val   = '0;
      unique case (state_q)
         S_IDLE: begin
            mem_we = prog_we_i;
            if (en_i) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         S_FETCH: begin
            if (en_i) begin
               instr_d = mem_q[pc_q];
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            pc_d    = pc_q + PA_W'(1);
            state_d = S_FETCH;
            unique case (op)
               4'h0: wr_en = 1'b0;
               4'h1: begin wr_en = 1'b1; wr_val = imm;   end
               4'h2: begin wr_en = 1'b1; wr_val = a + b; end
               4'h3: begin wr_en = 1'b1; wr_val = a - b; end
               4'h4: begin wr_en = 1'b1; wr_val = a & b; end
               4'h5: begin wr_en = 1'b1; wr_val = a | b; end
               4'h6: begin wr_en = 1'b1; wr_val = a ^ b; end
               4'h7: begin
                  wr_en  = 1'b1;
                  wr_val = {{(DATA_W-1){1'b0}},
                            ($signed(a) < $signed(b))};
               end
               4'h8: if (a == b) pc_d = pc_br;
               4'h9: if ($signed(a) < $signed(b)) pc_d = pc_br;
               4'hA: pc_d = pc_br;
               4'hB: begin
                  result_d = a;
                  valid_d  = 1'b1;
               end
               4'hF: state_d = S_HALT;
               default: begin
                  state_d = S_HALT;
                  err_d   = 1'b1;
               end
            endcase
            // r0 stays zero by never accepting a write
            if (wr_en && rd != '0) rf_d[rd] = wr_val;
         end
         S_HALT: begin
            if (!en_i) begin
               state_d = S_IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         instr_q  <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         rf_q     <= rf_d;
      end
   end

   // program memory survives reset
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[prog_addr_i] <= prog_data_i;
   end

   assign result_o       = result_q;
   assign result_valid_o = valid_q;
   assign busy_o         = (state_q == S_FETCH) || (state_q == S_EXEC);
   assign halt_o         = (state_q == S_HALT);
   assign err_o          = err_q;

endmodule

// File: tb/tb_prim_core_param.sv
// Directed bench for prim_core_param: three instances cover default,
// 8-bit data and a 4-word program memory.
module tb_prim_core_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en    [3];
   logic        we    [3];
   logic [15:0] addr  [3];
   logic [31:0] pdata [3];

   logic [31:0] res0, res2;
   logic [7:0]  res1;
   logic        vld   [3];
   logic        busy  [3];
   logic        halt  [3];
   logic        err   [3];

   int n_chk  = 0;
   int n_pass = 0;
   int vcnt, first_v, halt_j, busy_pause;
   logic [31:0] rlog [4];

   always #5 clk = ~clk;

   prim_core_param u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]),
      .prog_we_i(we[0]), .prog_addr_i(addr[0][5:0]),
      .prog_data_i(pdata[0]), .result_o(res0),
      .result_valid_o(vld[0]), .busy_o(busy[0]),
      .halt_o(halt[0]), .err_o(err[0])
   );

   prim_core_param #(.DATA_W(8), .PROG_DEPTH(8)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]),
      .prog_we_i(we[1]), .prog_addr_i(addr[1][2:0]),
      .prog_data_i(pdata[1]), .result_o(res1),
      .result_valid_o(vld[1]), .busy_o(busy[1]),
      .halt_o(halt[1]), .err_o(err[1])
   );

   prim_core_param #(.PROG_DEPTH(4)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en[2]),
      .prog_we_i(we[2]), .prog_addr_i(addr[2][1:0]),
      .prog_data_i(pdata[2]), .result_o(res2),
      .result_valid_o(vld[2]), .busy_o(busy[2]),
      .halt_o(halt[2]), .err_o(err[2])
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] ins(input logic [3:0] op,
                                       input logic [3:0] rd,
                                       input logic [3:0] rs1,
                                       input logic [3:0] rs2,
                                       input logic [15:0] imm);
      return {op, rd, rs1, rs2, imm};
   endfunction

   function automatic logic [31:0] get_res(input int d);
      case (d)
         0: return res0;
         1: return {24'h0, res1};
         default: return res2;
      endcase
   endfunction

   task automatic load(input int d, input int a, input logic [31:0] w);
      @(negedge clk);
      we[d]    = 1'b1;
      addr[d]  = 16'(a);
      pdata[d] = w;
      @(negedge clk);
      we[d]    = 1'b0;
   endtask

   task automatic run(input int d, input int maxcyc, input int pause_at,
                      input int pause_len, input int wr_at);
      vcnt = 0; first_v = -1; halt_j = -1; busy_pause = -1;
      for (int i = 0; i < 4; i++) rlog[i] = 32'hdead_beef;
      @(negedge clk);
      en[d] = 1'b1;
      for (int j = 0; j < maxcyc; j++) begin
         @(negedge clk);
         if (vld[d]) begin
            if (first_v < 0) first_v = j;
            if (vcnt < 4) rlog[vcnt] = get_res(d);
            vcnt++;
         end
         if (halt[d]) begin
            halt_j = j;
            break;
         end
         if (j == pause_at) en[d] = 1'b0;
         if (j == pause_at + 2) busy_pause = int'(busy[d]);
         if (j == pause_at + pause_len) en[d] = 1'b1;
         if (j == wr_at) begin
            we[d] = 1'b1; addr[d] = 16'd1;
            pdata[d] = ins(4'hB, 0, 0, 0, 0);
         end else begin
            we[d] = 1'b0;
         end
      end
      we[d] = 1'b0;
   endtask

   task automatic stop(input int d);
      en[d] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         en[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; pdata[i] = '0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_res",   res0,    0);
      chk("rst_valid", vld[0],  0);
      chk("rst_busy",  busy[0], 0);
      chk("rst_halt",  halt[0], 0);
      chk("rst_err",   err[0],  0);

      // test 1: 5 + 7
      load(0, 0, ins(4'h1, 1, 0, 0, 16'd5));
      load(0, 1, ins(4'h1, 2, 0, 0, 16'd7));
      load(0, 2, ins(4'h2, 3, 1, 2, 0));
      load(0, 3, ins(4'hB, 0, 3, 0, 0));
      load(0, 4, ins(4'hF, 0, 0, 0, 0));
      run(0, 60, -1, 0, -1);
      chk("t1_vtime", first_v, 8);
      chk("t1_res",   rlog[0], 12);
      chk("t1_vcnt",  vcnt,    1);
      chk("t1_halt",  halt_j,  10);
      chk("t1_err",   err[0],  0);
      stop(0);
      chk("t1_idle",  halt[0], 0);
      chk("t1_hold",  res0,    12);

      // test 4: 5-cycle pause while in FETCH
      run(0, 60, 2, 5, -1);
      chk("t4_busy",  busy_pause, 1);
      chk("t4_vtime", first_v, 13);
      chk("t4_res",   rlog[0], 12);
      chk("t4_halt",  halt_j,  15);
      stop(0);

      // test 6: async reset during EXEC, program retained
      @(negedge clk);
      en[0] = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_pre_busy", busy[0], 1);
      chk("t6_pre_res",  res0,    12);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_res",  res0,    0);
      chk("t6_rst_busy", busy[0], 0);
      chk("t6_rst_vld",  vld[0],  0);
      @(negedge clk);
      en[0] = 1'b0;
      rst_n = 1'b1;
      run(0, 60, -1, 0, -1);
      chk("t6_res",  rlog[0], 12);
      chk("t6_halt", halt_j,  10);
      stop(0);

      // test 5: illegal opcode, write attempt while running
      load(0, 0, ins(4'h1, 1, 0, 0, 16'd9));
      load(0, 1, ins(4'hB, 0, 1, 0, 0));
      load(0, 2, ins(4'hC, 0, 0, 0, 0));
      load(0, 3, ins(4'hF, 0, 0, 0, 0));
      run(0, 60, -1, 0, 0);
      chk("t5_halt", halt_j, 6);
      chk("t5_err",  err[0], 1);
      chk("t5_res",  rlog[0], 9);
      stop(0);
      chk("t5_err_clr", err[0],  0);
      chk("t5_idle",    halt[0], 0);
      run(0, 60, -1, 0, -1);
      chk("t5_rerun_res", rlog[0], 9);
      chk("t5_rerun_err", err[0],  1);
      stop(0);

      // test 2: countdown loop with BEQ/JMP
      load(0, 0, ins(4'h1, 1, 0, 0, 16'd3));
      load(0, 1, ins(4'h1, 2, 0, 0, 16'd0));
      load(0, 2, ins(4'h1, 4, 0, 0, 16'd1));
      load(0, 3, ins(4'h2, 2, 2, 1, 0));
      load(0, 4, ins(4'h3, 1, 1, 4, 0));
      load(0, 5, ins(4'h8, 0, 1, 0, 16'd2));
      load(0, 6, ins(4'hA, 0, 0, 0, 16'hFFFD));
      load(0, 7, ins(4'hB, 0, 2, 0, 0));
      load(0, 8, ins(4'hF, 0, 0, 0, 0));
      run(0, 80, -1, 0, -1);
      chk("t2_res",   rlog[0], 6);
      chk("t2_vcnt",  vcnt,    1);
      chk("t2_vtime", first_v, 30);
      chk("t2_halt",  halt_j,  32);
      chk("t2_err",   err[0],  0);
      stop(0);

      // test 3: 8-bit signed compare and wrap-around add
      load(1, 0, ins(4'h1, 1, 0, 0, 16'hFFFF));
      load(1, 1, ins(4'h7, 2, 1, 0, 0));
      load(1, 2, ins(4'h2, 3, 1, 1, 0));
      load(1, 3, ins(4'hB, 0, 2, 0, 0));
      load(1, 4, ins(4'hB, 0, 3, 0, 0));
      load(1, 5, ins(4'hF, 0, 0, 0, 0));
      run(1, 60, -1, 0, -1);
      chk("t3_slt",  rlog[0], 32'h01);
      chk("t3_add",  rlog[1], 32'hFE);
      chk("t3_vcnt", vcnt,    2);
      chk("t3_halt", halt_j,  12);
      stop(1);

      // pc wrap on a 4-word memory
      load(2, 0, ins(4'hB, 0, 1, 0, 0));
      load(2, 1, ins(4'h1, 1, 0, 0, 16'd7));
      load(2, 2, ins(4'h0, 0, 0, 0, 0));
      load(2, 3, ins(4'h0, 0, 0, 0, 0));
      run(2, 12, -1, 0, -1);
      chk("wrap_first",  rlog[0], 0);
      chk("wrap_second", rlog[1], 7);
      chk("wrap_vcnt",   vcnt,    2);
      chk("wrap_busy",   busy[2], 1);
      chk("wrap_nohalt", halt_j,  32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
